// File: rtl/p_mac_pkg.sv
// Shared types and helpers for the p_mac_stream multiply-accumulate engine.
package p_mac_pkg;

  localparam int P_WIDTH        = 8;
  localparam int P_MULT_LATENCY = 3;
  localparam int P_ACC_WIDTH    = 2*P_WIDTH + 8;
  localparam int P_EXT_MAX      = 128;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
    logic is_signed;
  } sb_t;

  localparam int SB_W = $bits(sb_t);

  // Bits at or above src_w are filled with the source MSB (signed) or zero.
  function automatic logic [P_EXT_MAX-1:0] ext_to_acc(input logic [P_EXT_MAX-1:0] val,
                                                       input int src_w,
                                                       input logic sgn);
    logic msb;
    msb = 1'b0;
    for (int i = 0; i < P_EXT_MAX; i++)
      if (i == src_w - 1) msb = val[i];
    for (int i = 0; i < P_EXT_MAX; i++)
      ext_to_acc[i] = (i < src_w) ? val[i] : (sgn & msb);
  endfunction

endpackage

// File: rtl/p_mac_pipe_stage.sv
// Enabled register slice with asynchronous active-low clear.
module p_mac_pipe_stage
  import p_mac_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/p_mac_stream.sv
// Pipelined multiply-accumulate over first/last delimited groups, valid/ready
// in and out; a single advance signal stalls every stage together.
module p_mac_stream
  import p_mac_pkg::*;
#(
  parameter int WIDTH        = P_WIDTH,
  parameter int MULT_LATENCY = P_MULT_LATENCY,
  parameter int ACC_WIDTH    = 2*WIDTH + 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     dataa,
  input  logic [WIDTH-1:0]     datab,
  input  logic                 is_signed,
  input  logic                 first,
  input  logic                 last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] res,
  output logic                 ovf
);

  localparam int PW = 2*WIDTH;
  localparam int SW = SB_W + PW;

  logic          adv;
  logic [SW-1:0] stage_d [0:MULT_LATENCY];
  logic [SW-1:0] stage_q [0:MULT_LATENCY];

  sb_t                      sb_in;
  sb_t                      sb_p0;
  logic signed [WIDTH:0]    ax_p0;
  logic signed [WIDTH:0]    bx_p0;
  logic signed [PW+1:0]     prod_full_p0;
  logic [PW-1:0]            prod_p0;
  logic [1:0]               prod_unused;

  sb_t                      sb_acc;
  logic [PW-1:0]            prod_acc;
  logic [P_EXT_MAX-1:0]     ext_full;
  logic [P_EXT_MAX-ACC_WIDTH-1:0] ext_unused;
  logic [ACC_WIDTH-1:0]     ext_p;
  logic [ACC_WIDTH-1:0]     base;
  logic [ACC_WIDTH:0]       sum_w;
  logic [ACC_WIDTH-1:0]     sum;
  logic                     ovf_base;
  logic                     step_ovf;
  logic                     ovf_next;

  logic [ACC_WIDTH-1:0]     acc;
  logic                     ovf_acc;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign sb_in = '{vld: in_valid, first: first, last: last, is_signed: is_signed};

  // Stage p0: operand register; product formed from it with a per-beat sign bit
  assign sb_p0        = stage_q[0][SW-1:PW];
  assign ax_p0        = {sb_p0.is_signed & stage_q[0][PW-1], stage_q[0][PW-1:WIDTH]};
  assign bx_p0        = {sb_p0.is_signed & stage_q[0][WIDTH-1], stage_q[0][WIDTH-1:0]};
  assign prod_full_p0 = ax_p0 * bx_p0;
  assign prod_p0      = prod_full_p0[PW-1:0];
  assign prod_unused  = prod_full_p0[PW+1:PW];

  genvar g;
  generate
    for (g = 0; g <= MULT_LATENCY; g++) begin : g_stage
      if (g == 0) begin : g_in
        assign stage_d[g] = {sb_in, dataa, datab};
      end else if (g == 1) begin : g_mul
        assign stage_d[g] = {sb_p0, prod_p0};
      end else begin : g_shift
        assign stage_d[g] = stage_q[g-1];
      end
      p_mac_pipe_stage #(.W(SW)) u_stage (
        .clk   (clk),
        .reset (reset),
        .en    (adv),
        .d     (stage_d[g]),
        .q     (stage_q[g])
      );
    end
  endgenerate

  // Accumulate stage: extend the product, add, and track overflow per signedness
  assign sb_acc     = stage_q[MULT_LATENCY][SW-1:PW];
  assign prod_acc   = stage_q[MULT_LATENCY][PW-1:0];
  assign ext_full   = ext_to_acc(P_EXT_MAX'(prod_acc), PW, sb_acc.is_signed);
  assign ext_p      = ext_full[ACC_WIDTH-1:0];
  assign ext_unused = ext_full[P_EXT_MAX-1:ACC_WIDTH];

  always_comb begin
    base     = sb_acc.first ? '0 : acc;
    ovf_base = sb_acc.first ? 1'b0 : ovf_acc;
    sum_w    = {1'b0, base} + {1'b0, ext_p};
    sum      = sum_w[ACC_WIDTH-1:0];
    if (sb_acc.is_signed)
      step_ovf = (base[ACC_WIDTH-1] == ext_p[ACC_WIDTH-1]) &&
                 (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
    else
      step_ovf = sum_w[ACC_WIDTH];
    ovf_next = ovf_base | step_ovf;
  end

  // A fresh result wins over the handshake of the previous one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      ovf_acc   <= 1'b0;
      res       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= sb_acc.vld && sb_acc.last;
      if (sb_acc.vld) begin
        if (sb_acc.last) begin
          res     <= sum;
          ovf     <= ovf_next;
          acc     <= '0;
          ovf_acc <= 1'b0;
        end else begin
          acc     <= sum;
          ovf_acc <= ovf_next;
        end
      end
    end
  end

endmodule
